// File: rtl/cache_rd_arbiter.sv
// Round-robin arbiter steering icache/dcache read misses onto one bridge read port.
// Grant is combinational in IDLE, bridge request follows one cycle later; returns are routed combinationally.
module cache_rd_arbiter #(
    parameter int LINE_OFF_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,

    input  logic        ic_rd_req,
    input  logic [2:0]  ic_rd_type,
    input  logic [31:0] ic_rd_addr,
    output logic        ic_rd_rdy,
    output logic        ic_ret_valid,
    output logic        ic_ret_last,
    output logic [31:0] ic_ret_data,

    input  logic        dc_rd_req,
    input  logic [2:0]  dc_rd_type,
    input  logic [31:0] dc_rd_addr,
    input  logic        dc_rd_lb,
    output logic        dc_rd_rdy,
    output logic        dc_ret_valid,
    output logic        dc_ret_last,
    output logic [31:0] dc_ret_data,

    output logic        rd_req_o,
    output logic [2:0]  rd_type_o,
    output logic [31:0] rd_addr_o,
    output logic        rd_lb_o,
    input  logic        rd_rdy_i,
    input  logic        ret_valid_i,
    input  logic        ret_last_i,
    input  logic [31:0] ret_data_i,
    input  logic        wr_pending_i,
    input  logic [31:0] wr_line_addr_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        grant_dc;
    logic        last_grant_dc;
    logic [2:0]  type_q;
    logic [31:0] addr_q;
    logic        lb_q;

    logic ic_elig, dc_elig, pick_ic, pick_dc, grant_fire, active, ret_done;

    // Low offset bits of the write-back address never take part in the line compare.
    logic unused_wr_off;
    assign unused_wr_off = ^wr_line_addr_i[LINE_OFF_W-1:0];

    assign ic_elig = ic_rd_req &&
        !(wr_pending_i && ic_rd_addr[31:LINE_OFF_W] == wr_line_addr_i[31:LINE_OFF_W]);
    assign dc_elig = dc_rd_req &&
        !(wr_pending_i && dc_rd_addr[31:LINE_OFF_W] == wr_line_addr_i[31:LINE_OFF_W]);

    // On a tie the side that did not win last time gets the grant.
    assign pick_ic    = ic_elig && (!dc_elig || last_grant_dc);
    assign pick_dc    = dc_elig && (!ic_elig || !last_grant_dc);
    assign active     = !reset && !flush;
    assign grant_fire = active && (state == IDLE) && (ic_elig || dc_elig);
    assign ret_done   = ret_valid_i && ret_last_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (ic_elig || dc_elig) state_nxt = REQ;
                REQ: begin
                    if (ret_done)       state_nxt = IDLE;
                    else if (!rd_rdy_i) state_nxt = RESP;
                end
                RESP: if (ret_done) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_dc      <= 1'b0;
            last_grant_dc <= 1'b1;
            type_q        <= 3'd0;
            addr_q        <= 32'd0;
            lb_q          <= 1'b0;
        end else if (flush) begin
            grant_dc <= 1'b0;
            type_q   <= 3'd0;
            addr_q   <= 32'd0;
            lb_q     <= 1'b0;
        end else if (grant_fire) begin
            grant_dc      <= pick_dc;
            last_grant_dc <= pick_dc;
            type_q        <= pick_dc ? dc_rd_type : ic_rd_type;
            addr_q        <= pick_dc ? dc_rd_addr : ic_rd_addr;
            lb_q          <= pick_dc && dc_rd_lb;
        end
    end

    always_comb begin
        ic_rd_rdy    = 1'b0;
        dc_rd_rdy    = 1'b0;
        rd_req_o     = 1'b0;
        ic_ret_valid = 1'b0;
        ic_ret_last  = 1'b0;
        ic_ret_data  = 32'd0;
        dc_ret_valid = 1'b0;
        dc_ret_last  = 1'b0;
        dc_ret_data  = 32'd0;
        if (active) begin
            if (state == IDLE) begin
                ic_rd_rdy = pick_ic;
                dc_rd_rdy = pick_dc;
            end else begin
                rd_req_o = (state == REQ);
                if (grant_dc) begin
                    dc_ret_valid = ret_valid_i;
                    dc_ret_last  = ret_done;
                    dc_ret_data  = ret_data_i;
                end else begin
                    ic_ret_valid = ret_valid_i;
                    ic_ret_last  = ret_done;
                    ic_ret_data  = ret_data_i;
                end
            end
        end
    end

    assign rd_type_o = type_q;
    assign rd_addr_o = addr_q;
    assign rd_lb_o   = lb_q;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Randomized bench for cache_rd_arbiter against a transaction-level model of the arbiter.
module tb_cache_rd_arbiter;
    localparam int LOFF = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush;
    logic        ic_rd_req, ic_rd_rdy, ic_ret_valid, ic_ret_last;
    logic [2:0]  ic_rd_type;
    logic [31:0] ic_rd_addr, ic_ret_data;
    logic        dc_rd_req, dc_rd_lb, dc_rd_rdy, dc_ret_valid, dc_ret_last;
    logic [2:0]  dc_rd_type;
    logic [31:0] dc_rd_addr, dc_ret_data;
    logic        rd_req_o, rd_lb_o, rd_rdy_i, ret_valid_i, ret_last_i, wr_pending_i;
    logic [2:0]  rd_type_o;
    logic [31:0] rd_addr_o, ret_data_i, wr_line_addr_i;

    cache_rd_arbiter #(.LINE_OFF_W(LOFF)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
        .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_lb(dc_rd_lb), .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid),
        .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
        .rd_req_o(rd_req_o), .rd_type_o(rd_type_o), .rd_addr_o(rd_addr_o), .rd_lb_o(rd_lb_o),
        .rd_rdy_i(rd_rdy_i), .ret_valid_i(ret_valid_i), .ret_last_i(ret_last_i),
        .ret_data_i(ret_data_i), .wr_pending_i(wr_pending_i), .wr_line_addr_i(wr_line_addr_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: which cache owns the bridge (-1 = none), whether its address was taken,
    // who won the previous grant (1 = dcache) and the captured request fields.
    int          m_owner;
    bit          m_sent;
    bit          m_last;
    logic [2:0]  m_type;
    logic [31:0] m_addr;
    bit          m_lb;

    logic [31:0] lines [4] = '{32'h8000_0040, 32'h8000_0060, 32'h1FC0_0000, 32'h0000_1000};

    function automatic bit eligible(input logic req, input logic [31:0] a);
        return req && !(wr_pending_i && (a >> LOFF) == (wr_line_addr_i >> LOFF));
    endfunction

    function automatic int winner();
        bit ie, de;
        ie = eligible(ic_rd_req, ic_rd_addr);
        de = eligible(dc_rd_req, dc_rd_addr);
        if (ie && de) return m_last ? 0 : 1;
        if (ie) return 0;
        if (de) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_sent = 0; m_last = 1;
        m_type = '0; m_addr = '0; m_lb = 0;
    endtask

    task automatic check_all();
        int w, own;
        w   = -1;
        own = -1;
        if (!reset && !flush) begin
            if (m_owner < 0) w = winner();
            else own = m_owner;
        end
        chk("ic_rd_rdy", ic_rd_rdy, w == 0);
        chk("dc_rd_rdy", dc_rd_rdy, w == 1);
        chk("rd_req_o", rd_req_o, own >= 0 && !m_sent);
        chk("rd_type_o", rd_type_o, reset ? 3'd0 : m_type);
        chk("rd_addr_o", rd_addr_o, reset ? 32'd0 : m_addr);
        chk("rd_lb_o", rd_lb_o, reset ? 1'b0 : m_lb);
        chk("ic_ret_valid", ic_ret_valid, own == 0 && ret_valid_i);
        chk("ic_ret_last", ic_ret_last, own == 0 && ret_valid_i && ret_last_i);
        chk("ic_ret_data", ic_ret_data, own == 0 ? ret_data_i : 32'd0);
        chk("dc_ret_valid", dc_ret_valid, own == 1 && ret_valid_i);
        chk("dc_ret_last", dc_ret_last, own == 1 && ret_valid_i && ret_last_i);
        chk("dc_ret_data", dc_ret_data, own == 1 ? ret_data_i : 32'd0);
    endtask

    task automatic model_step();
        int w;
        if (reset) begin
            model_reset();
        end else if (flush) begin
            m_owner = -1; m_sent = 0;
            m_type = '0; m_addr = '0; m_lb = 0;
        end else if (m_owner < 0) begin
            w = winner();
            if (w >= 0) begin
                m_owner = w;
                m_sent  = 0;
                m_last  = (w == 1);
                m_type  = (w == 1) ? dc_rd_type : ic_rd_type;
                m_addr  = (w == 1) ? dc_rd_addr : ic_rd_addr;
                m_lb    = (w == 1) && dc_rd_lb;
            end
        end else if (ret_valid_i && ret_last_i) begin
            m_owner = -1;
        end else if (!m_sent && !rd_rdy_i) begin
            m_sent = 1;
        end
    endtask

    task automatic drive_random();
        reset          = 1'b0;
        flush          = ($urandom_range(0, 49) == 0);
        ic_rd_req      = ($urandom_range(0, 9) < 6);
        ic_rd_type     = 3'($urandom_range(0, 7));
        ic_rd_addr     = lines[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
        dc_rd_req      = ($urandom_range(0, 9) < 6);
        dc_rd_type     = 3'($urandom_range(0, 7));
        dc_rd_addr     = lines[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
        dc_rd_lb       = 1'($urandom_range(0, 1));
        wr_pending_i   = ($urandom_range(0, 9) < 3);
        wr_line_addr_i = lines[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
        rd_rdy_i       = 1'($urandom_range(0, 1));
        ret_valid_i    = 1'($urandom_range(0, 1));
        ret_last_i     = ($urandom_range(0, 9) < 3);
        ret_data_i     = $urandom;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        ic_rd_req = 0; ic_rd_type = '0; ic_rd_addr = '0;
        dc_rd_req = 0; dc_rd_type = '0; dc_rd_addr = '0; dc_rd_lb = 0;
        rd_rdy_i = 1; ret_valid_i = 0; ret_last_i = 0; ret_data_i = '0;
        wr_pending_i = 0; wr_line_addr_i = '0;
        model_reset();

        @(negedge clk);
        #1 check_all();
        @(posedge clk);
        model_step();

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            drive_random();
            #1 check_all();
            // Occasionally hit reset asynchronously while a transaction is outstanding.
            if (m_owner >= 0 && $urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                #1 check_all();
            end
            @(posedge clk);
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_rd_arbiter.md
Name: cache_rd_arbiter

Overview:
- Arbitrates read-miss requests from the icache and the dcache onto the single cache-side read port of the AXI bridge.
- Sits directly upstream of the bridge: rd_req / rd_type / rd_addr / rd_lb go out to the bridge; ret_valid / ret_last / ret_data come back and are steered to the granted cache.
- Holds one outstanding bridge read at a time, with round-robin fairness.
- Blocks any read that hits the line the bridge is currently writing back.

Parameters:
- LINE_OFF_W, 5, byte-offset width of a cache line (32 B = 256-bit line); address bits [31:LINE_OFF_W] identify the line.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  pipeline flush; aborts the current transaction
- ic_rd_req  in  1  icache read request
- ic_rd_type  in  3  3'b100 = 8-beat line, 3'b111 = 2-beat, other = single
- ic_rd_addr  in  32  icache read address
- ic_rd_rdy  out  1  icache request accepted this cycle
- ic_ret_valid  out  1  icache return beat valid
- ic_ret_last  out  1  icache last return beat
- ic_ret_data  out  32  icache return data
- dc_rd_req, dc_rd_type, dc_rd_addr, dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data  same as ic_*, for the dcache
- dc_rd_lb  in  1  dcache byte-size uncached read
- rd_req_o  out  1  request to bridge
- rd_type_o  out  3  latched type
- rd_addr_o  out  32  latched address
- rd_lb_o  out  1  latched lb; always 0 for icache
- rd_rdy_i  in  1  bridge read idle
- ret_valid_i  in  1  bridge return valid
- ret_last_i  in  1  bridge return last
- ret_data_i  in  32  bridge return data
- wr_pending_i  in  1  bridge write-back in progress
- wr_line_addr_i  in  32  address of the in-flight write-back

Behaviour:
- Reset (async) and flush (sync, takes priority over all transitions):
  - state <- IDLE; all outputs 0.
  - Latched type/addr/lb <- 0.
  - last_grant <- DC on reset; last_grant is unchanged by flush.
- Eligibility: a request is eligible iff req=1 and NOT (wr_pending_i and addr[31:LINE_OFF_W] == wr_line_addr_i[31:LINE_OFF_W]).
- States:
  - IDLE:
    - If any request is eligible, grant it; if both are eligible, grant the one that is not last_grant.
    - For the granted cache: assert its *_rd_rdy for exactly this cycle (combinational on req and eligibility).
    - Latch type/addr/lb, set grant_id and last_grant, go to REQ.
    - rd_req_o = 0 in IDLE.
  - REQ:
    - rd_req_o = 1; rd_type_o, rd_addr_o and rd_lb_o are driven from the latched registers and stay stable.
    - rd_rdy_i = 0 means the bridge accepted the address: go to RESP.
    - ret_valid_i & ret_last_i in REQ: go to IDLE.
  - RESP:
    - rd_req_o = 0.
    - ret_valid_i & ret_last_i: go to IDLE.
- Return routing, REQ and RESP only:
  - Granted cache: *_ret_valid = ret_valid_i, *_ret_last = ret_valid_i & ret_last_i, *_ret_data = ret_data_i.
  - Other cache: all three = 0.
  - In IDLE both sides are 0; stray beats are dropped.
- Latency:
  - Request to rd_rdy: 0 cycles.
  - rd_rdy to rd_req_o: 1 cycle.
  - Return path: combinational, 0 cycles.
- No new grant is issued in the cycle the last beat returns. The earliest next rd_rdy is the following cycle.
- Requests arriving while in REQ/RESP are held off (rd_rdy = 0). Caches keep their req asserted.
- Hazard clearing: a blocked request is granted in the first IDLE cycle after wr_pending_i falls.
- One grant per IDLE visit.

Test Plan:
- ic only, addr 0x1FC0_0000, type 3'b100, 8 beats 0x11..0x88 → ic_rd_rdy in cycle 0; rd_req_o=1 with addr 0x1FC0_0000 from cycle 1; icache sees 8 beats with ic_ret_last on 0x88; dc_ret_* stay 0.
- ic and dc requesting together after reset → icache granted first; on its return, dcache granted in the cycle after ret_last; on a third simultaneous request, icache wins again.
- wr_pending_i=1 with wr_line_addr_i=0x8000_0040 and dc_rd_addr=0x8000_005C → dc_rd_rdy=0. Drop wr_pending_i → grant in the next cycle. Same test with dc_rd_addr=0x8000_0060 → granted immediately.
- dc uncached byte read, dc_rd_lb=1, type 3'b000 → rd_lb_o=1; single beat returned with dc_ret_last=1; state back in IDLE the next cycle.
- flush asserted in RESP mid-burst after beat 3 → next cycle state IDLE, all ret outputs 0, remaining beats ignored; a new request is granted normally.
- reset asserted asynchronously mid-REQ → rd_req_o drops without waiting for a clock edge; all outputs 0; on release, a tie goes to icache.
